// File: rtl/hdmi_packet_pkg.sv
// Shared constants, subpacket payload type and the BCH ECC step for the
// HDMI data island packet assembler.
package hdmi_packet_pkg;

    localparam int unsigned PACKET_LEN  = 32;
    localparam int unsigned HEADER_BITS = 24;
    localparam int unsigned SUB_BITS    = 56;
    localparam int unsigned NUM_SUB     = 4;
    localparam int unsigned ECC_BITS    = 8;
    localparam logic [ECC_BITS-1:0] ECC_POLY = 8'h83;

    // Four 56-bit subpackets; byte 0 of each in [7:0].
    typedef logic [NUM_SUB-1:0][SUB_BITS-1:0] sub_array_t;

    // One serial step of the BCH(64,56)/(32,24) ECC LFSR.
    function automatic logic [ECC_BITS-1:0] ecc_step(input logic [ECC_BITS-1:0] ecc,
                                                     input logic                b);
        logic fb;
        fb = ecc[0] ^ b;
        return (ecc >> 1) ^ (fb ? ECC_POLY : '0);
    endfunction

endpackage

// File: rtl/bch_ecc.sv
// Per-stream BCH ECC register.
// Ports:
//   clk_pixel  in   pixel clock
//   reset      in   synchronous active-high reset, clears the register
//   bits       in   BITS_PER_CLK payload bits, bit 0 folded first
//   hold       in   keep the register unchanged this clock
//   seed_zero  in   fold from a zero seed instead of the stored value
//   ecc        out  current ECC register
module bch_ecc
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned BITS_PER_CLK = 1
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic [BITS_PER_CLK-1:0] bits,
    input  logic                    hold,
    input  logic                    seed_zero,
    output logic [ECC_BITS-1:0]     ecc
);

    logic [ECC_BITS-1:0] base;
    logic [ECC_BITS-1:0] ecc_d;

    // Fold this clock's bits, lowest index first.
    always_comb begin
        base  = seed_zero ? '0 : ecc;
        ecc_d = base;
        if (!hold) begin
            for (int i = 0; i < int'(BITS_PER_CLK); i++) begin
                ecc_d = ecc_step(ecc_d, bits[i]);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            ecc <= '0;
        end else begin
            ecc <= ecc_d;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// HDMI data island packet assembler: serialises a 24-bit header and four
// 56-bit subpackets over 32 pixel clocks, appending BCH ECC to each stream.
// Optional macro PACKET_ASSEMBLER_LATCH_EN captures header/sub at the
// start of each packet so the source may change them mid-packet.
// Ports:
//   clk_pixel           in   pixel clock
//   reset               in   synchronous active-high reset
//   data_island_period  in   high while a packet is being sent
//   header              in   packet header, HB0 in [7:0]
//   sub                 in   subpackets 0..3, byte 0 in [7:0]
//   packet_data         out  TERC4 payload bits (combinational, zero latency)
//   counter             out  bit position within the packet
//   packet_last         out  high on the final clock of a packet
module packet_assembler
    import hdmi_packet_pkg::*;
(
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic [4:0]       counter,
    output logic             packet_last
);

    logic [HEADER_BITS-1:0] hdr_src;
    sub_array_t             sub_src;

`ifdef PACKET_ASSEMBLER_LATCH_EN
    logic [HEADER_BITS-1:0] hdr_q;
    sub_array_t             sub_q;

    // Capture the packet contents on its first clock.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_q <= '0;
            sub_q <= '0;
        end else if (data_island_period && counter == 5'd0) begin
            hdr_q <= header;
            sub_q <= sub;
        end
    end

    // The latches are not yet loaded on the first clock, so use the inputs.
    assign hdr_src = (counter == 5'd0) ? header : hdr_q;
    assign sub_src = (counter == 5'd0) ? sub    : sub_q;
`else
    assign hdr_src = header;
    assign sub_src = sub;
`endif

    logic                active;
    logic                first;
    logic                hdr_data;
    logic                sub_data;
    logic                hdr_bit;
    logic [5:0]          sub_lo_idx;
    logic [5:0]          sub_hi_idx;
    logic [1:0]          sub_bits [NUM_SUB];
    logic [ECC_BITS-1:0] hdr_ecc;
    logic [ECC_BITS-1:0] sub_ecc  [NUM_SUB];

    assign active     = data_island_period && !reset;
    assign first      = (counter == 5'd0);
    assign hdr_data   = (counter < 5'(HEADER_BITS));
    assign sub_data   = (counter < 5'(SUB_BITS / 2));
    assign hdr_bit    = hdr_data ? hdr_src[counter] : 1'b0;
    assign sub_lo_idx = {counter, 1'b0};
    assign sub_hi_idx = {counter, 1'b1};

    // Position counter; any gap in the data island abandons the packet.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter <= '0;
        end else if (!data_island_period) begin
            counter <= '0;
        end else begin
            counter <= counter + 5'd1;
        end
    end

    bch_ecc #(.BITS_PER_CLK(1)) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bits      (hdr_bit),
        .hold      (!data_island_period || !hdr_data),
        .seed_zero (first),
        .ecc       (hdr_ecc)
    );

    for (genvar k = 0; k < int'(NUM_SUB); k++) begin : g_sub
        assign sub_bits[k] = data_island_period && sub_data
                             ? {sub_src[k][sub_hi_idx], sub_src[k][sub_lo_idx]} : 2'b00;

        bch_ecc #(.BITS_PER_CLK(2)) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .bits      (sub_bits[k]),
            .hold      (!data_island_period || !sub_data),
            .seed_zero (first),
            .ecc       (sub_ecc[k])
        );
    end

    // Payload mux: data bits first, then the held ECC, LSB first.
    always_comb begin
        packet_data = '0;
        if (active) begin
            packet_data[0] = hdr_data ? hdr_bit : hdr_ecc[counter[2:0]];
            for (int k = 0; k < int'(NUM_SUB); k++) begin
                packet_data[1+k] = sub_data ? sub_bits[k][0] : sub_ecc[k][{counter[1:0], 1'b0}];
                packet_data[5+k] = sub_data ? sub_bits[k][1] : sub_ecc[k][{counter[1:0], 1'b1}];
            end
        end
    end

    assign packet_last = active && (counter == 5'(PACKET_LEN - 1));

endmodule
